// File: rtl/k_and_s_pkg.sv
// Shared types and constants for the K&S multicycle controller.
// Latency: n/a (types only).
// Backpressure: n/a.
//
// Contents: decoded instruction enum, ALU op encodings, controller state enum,
// and a helper that maps an ALU instruction to its operation code.
package k_and_s_pkg;

  typedef enum logic [3:0] {
    I_NOP,
    I_LOAD,
    I_STORE,
    I_MOVE,
    I_ADD,
    I_SUB,
    I_AND,
    I_OR,
    I_BRANCH,
    I_BZERO,
    I_BNZERO,
    I_BNEG,
    I_BNNEG,
    I_BOV,
    I_BNOV,
    I_HALT
  } decoded_instruction_type;

  localparam logic [1:0] OP_OR  = 2'b00;
  localparam logic [1:0] OP_ADD = 2'b01;
  localparam logic [1:0] OP_SUB = 2'b10;
  localparam logic [1:0] OP_AND = 2'b11;

  typedef enum logic [3:0] {
    S_FETCH,
    S_LATCH_IR,
    S_DECODE,
    S_EXEC_ALU,
    S_EXEC_MOVE,
    S_LOAD_ADDR,
    S_LOAD_WB,
    S_STORE_WR,
    S_BRANCH,
    S_HALTED
  } ctrl_state_t;

  // MOVE and every non-ALU instruction fall through to OR (pass-through).
  function automatic logic [1:0] alu_op(input decoded_instruction_type instr);
    case (instr)
      I_ADD:   return OP_ADD;
      I_SUB:   return OP_SUB;
      I_AND:   return OP_AND;
      default: return OP_OR;
    endcase
  endfunction

endpackage

// File: rtl/ks_multicycle_ctrl_if.sv
// Controller <-> datapath bundle: decoded instruction and flags in, strobes out.
// Latency: n/a (wiring only).
// Backpressure: none; the datapath consumes every strobe in the cycle it is high.
//
// master: the control FSM (drives strobes, reads instruction/flags).
// slave:  the datapath (reads strobes, drives instruction/flags).
interface ks_multicycle_ctrl_if #(
  parameter int CNT_W = 16
);
  import k_and_s_pkg::*;

  decoded_instruction_type decoded_instruction;
  logic                    zero_op;
  logic                    neg_op;
  logic                    unsigned_overflow;
  logic                    signed_overflow;

  logic                    branch;
  logic                    pc_enable;
  logic                    ir_enable;
  logic                    write_reg_enable;
  logic                    addr_sel;
  logic                    c_sel;
  logic [1:0]              operation;
  logic                    flags_reg_enable;
  logic                    ram_write_enable;
  logic                    halt;
  logic [CNT_W-1:0]        instr_retired;

  modport master (
    input  decoded_instruction, zero_op, neg_op, unsigned_overflow, signed_overflow,
    output branch, pc_enable, ir_enable, write_reg_enable, addr_sel, c_sel,
           operation, flags_reg_enable, ram_write_enable, halt, instr_retired
  );

  modport slave (
    output decoded_instruction, zero_op, neg_op, unsigned_overflow, signed_overflow,
    input  branch, pc_enable, ir_enable, write_reg_enable, addr_sel, c_sel,
           operation, flags_reg_enable, ram_write_enable, halt, instr_retired
  );

endinterface

// File: rtl/ks_wait_counter.sv
// RAM wait counter: asserts done on the last of MEM_LATENCY enabled cycles.
// Latency: done is combinational from the count; count advances one per enabled cycle.
// Backpressure: none; clear has priority over enable.
//
// Ports: clk, rst_n, clear (return to 0), enable (count this cycle), done (last wait cycle).
module ks_wait_counter #(
  parameter int MEM_LATENCY = 1
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clear,
  input  logic enable,
  output logic done
);

  localparam int W = $clog2(MEM_LATENCY + 1);
  localparam logic [W-1:0] LAST = W'(MEM_LATENCY - 1);

  logic [W-1:0] wait_cnt;

  assign done = enable && (wait_cnt == LAST);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wait_cnt <= '0;
    end else if (clear) begin
      wait_cnt <= '0;
    end else if (enable) begin
      wait_cnt <= wait_cnt + 1'b1;
    end
  end

endmodule

// File: rtl/ks_multicycle_ctrl.sv
// Multicycle control FSM for the K&S processor, driving datapath strobes.
// Latency: NOP/not-taken branch L+2, ALU/MOVE/STORE/taken branch L+3, LOAD 2L+3 (L = MEM_LATENCY).
// Backpressure: none; RAM wait is a fixed MEM_LATENCY cycles per fetch/load.
//
// Ports: clk, rst_n (async active-low), bus (master modport: instruction and
// flags in; strobes, sticky halt and saturating instr_retired out).
module ks_multicycle_ctrl
  import k_and_s_pkg::*;
#(
  parameter int MEM_LATENCY = 1,
  parameter int OV_SIGNED   = 1,
  parameter int CNT_W       = 16
) (
  input  logic                   clk,
  input  logic                   rst_n,
  ks_multicycle_ctrl_if.master   bus
);

  generate
    if (MEM_LATENCY < 1) begin : g_bad_latency
      $error("ks_multicycle_ctrl: MEM_LATENCY must be >= 1");
    end
  endgenerate

  ctrl_state_t state;
  ctrl_state_t nxt;
  logic        ov;
  logic        taken;
  logic        wait_en;
  logic        wait_clr;
  logic        wait_done;
  logic        retire;

  // Both RAM-wait states share one counter; it is idle (and zero) elsewhere.
  assign wait_en  = (state == S_FETCH) || (state == S_LOAD_ADDR);
  assign wait_clr = (nxt != state);

  ks_wait_counter #(
    .MEM_LATENCY(MEM_LATENCY)
  ) u_wait (
    .clk   (clk),
    .rst_n (rst_n),
    .clear (wait_clr),
    .enable(wait_en),
    .done  (wait_done)
  );

  // Branch-condition mux; flags are sampled while in DECODE.
  always_comb begin
    ov    = (OV_SIGNED != 0) ? bus.signed_overflow : bus.unsigned_overflow;
    taken = 1'b0;
    case (bus.decoded_instruction)
      I_BRANCH: taken = 1'b1;
      I_BZERO:  taken = bus.zero_op;
      I_BNZERO: taken = !bus.zero_op;
      I_BNEG:   taken = bus.neg_op;
      I_BNNEG:  taken = !bus.neg_op;
      I_BOV:    taken = ov;
      I_BNOV:   taken = !ov;
      default:  taken = 1'b0;
    endcase
  end

  always_comb begin
    nxt = state;
    case (state)
      S_FETCH:     if (wait_done) nxt = S_LATCH_IR;
      S_LATCH_IR:  nxt = S_DECODE;
      S_DECODE: begin
        case (bus.decoded_instruction)
          I_ADD, I_SUB, I_AND, I_OR:  nxt = S_EXEC_ALU;
          I_MOVE:                     nxt = S_EXEC_MOVE;
          I_LOAD:                     nxt = S_LOAD_ADDR;
          I_STORE:                    nxt = S_STORE_WR;
          I_BRANCH, I_BZERO, I_BNZERO, I_BNEG, I_BNNEG, I_BOV, I_BNOV:
                                      nxt = taken ? S_BRANCH : S_FETCH;
          I_HALT:                     nxt = S_HALTED;
          default:                    nxt = S_FETCH;
        endcase
      end
      S_EXEC_ALU, S_EXEC_MOVE, S_LOAD_WB, S_STORE_WR, S_BRANCH:
                   nxt = S_FETCH;
      S_LOAD_ADDR: if (wait_done) nxt = S_LOAD_WB;
      S_HALTED:    nxt = S_HALTED;
      default:     nxt = S_FETCH;
    endcase
  end

  // Only instruction-completing states ever re-enter FETCH, so any entry retires.
  assign retire = ((nxt == S_FETCH) && (state != S_FETCH)) ||
                  ((nxt == S_HALTED) && (state != S_HALTED));

  // Outputs are registered from the next state, so they line up with the
  // state register and stay glitch-free.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state                <= S_FETCH;
      bus.branch           <= 1'b0;
      bus.pc_enable        <= 1'b0;
      bus.ir_enable        <= 1'b0;
      bus.write_reg_enable <= 1'b0;
      bus.addr_sel         <= 1'b0;
      bus.c_sel            <= 1'b0;
      bus.operation        <= OP_OR;
      bus.flags_reg_enable <= 1'b0;
      bus.ram_write_enable <= 1'b0;
      bus.halt             <= 1'b0;
      bus.instr_retired    <= '0;
    end else begin
      state                <= nxt;
      bus.branch           <= (nxt == S_BRANCH);
      bus.pc_enable        <= (nxt == S_LATCH_IR) || (nxt == S_BRANCH);
      bus.ir_enable        <= (nxt == S_LATCH_IR);
      bus.write_reg_enable <= (nxt == S_EXEC_ALU) || (nxt == S_EXEC_MOVE) || (nxt == S_LOAD_WB);
      bus.addr_sel         <= (nxt == S_LOAD_ADDR) || (nxt == S_LOAD_WB) || (nxt == S_STORE_WR);
      bus.c_sel            <= (nxt == S_LOAD_WB);
      // The op is captured on the DECODE->EXEC_ALU edge and held for that one cycle.
      bus.operation        <= (nxt == S_EXEC_ALU) ? alu_op(bus.decoded_instruction) : OP_OR;
      bus.flags_reg_enable <= (nxt == S_EXEC_ALU);
      bus.ram_write_enable <= (nxt == S_STORE_WR);
      bus.halt             <= (nxt == S_HALTED);
      if (retire && (bus.instr_retired != '1)) begin
        bus.instr_retired <= bus.instr_retired + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_ks_multicycle_ctrl.sv
// Directed bench for ks_multicycle_ctrl using three parameterisations.
// A: L=1 signed-ov CNT_W=16; B: L=3; C: L=1 unsigned-ov CNT_W=2.
module tb_ks_multicycle_ctrl;
  import k_and_s_pkg::*;

  logic clk;
  logic rst_n;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  ks_multicycle_ctrl_if #(.CNT_W(16)) ia ();
  ks_multicycle_ctrl_if #(.CNT_W(16)) ib ();
  ks_multicycle_ctrl_if #(.CNT_W(2))  ic ();

  ks_multicycle_ctrl #(.MEM_LATENCY(1), .OV_SIGNED(1), .CNT_W(16)) u_a (.clk(clk), .rst_n(rst_n), .bus(ia));
  ks_multicycle_ctrl #(.MEM_LATENCY(3), .OV_SIGNED(1), .CNT_W(16)) u_b (.clk(clk), .rst_n(rst_n), .bus(ib));
  ks_multicycle_ctrl #(.MEM_LATENCY(1), .OV_SIGNED(0), .CNT_W(2))  u_c (.clk(clk), .rst_n(rst_n), .bus(ic));

  // Strobe vector: {halt, branch, pc_en, ir_en, wr, addr_sel, c_sel, op[1:0], flags, ram_we}
  logic [10:0] va, vb, vc;
  assign va = {ia.halt, ia.branch, ia.pc_enable, ia.ir_enable, ia.write_reg_enable, ia.addr_sel,
               ia.c_sel, ia.operation, ia.flags_reg_enable, ia.ram_write_enable};
  assign vb = {ib.halt, ib.branch, ib.pc_enable, ib.ir_enable, ib.write_reg_enable, ib.addr_sel,
               ib.c_sel, ib.operation, ib.flags_reg_enable, ib.ram_write_enable};
  assign vc = {ic.halt, ic.branch, ic.pc_enable, ic.ir_enable, ic.write_reg_enable, ic.addr_sel,
               ic.c_sel, ic.operation, ic.flags_reg_enable, ic.ram_write_enable};

  localparam logic [10:0] V_IDLE  = 11'h000; // FETCH, DECODE
  localparam logic [10:0] V_LATCH = 11'h180; // pc_en + ir_en
  localparam logic [10:0] V_ADD   = 11'h046; // wr + op=01 + flags
  localparam logic [10:0] V_LADDR = 11'h020; // addr_sel
  localparam logic [10:0] V_LWB   = 11'h070; // wr + addr_sel + c_sel
  localparam logic [10:0] V_STORE = 11'h021; // addr_sel + ram_we
  localparam logic [10:0] V_BR    = 11'h300; // branch + pc_en
  localparam logic [10:0] V_HALT  = 11'h400; // halt

  int n_checks = 0;
  int n_fail   = 0;

  task automatic chk_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Check the strobe vector of one instance for the current cycle, then advance a cycle.
  task automatic exp_cyc(input int inst, input string tag, input logic [10:0] e);
    logic [10:0] v;
    case (inst)
      0:       v = va;
      1:       v = vb;
      default: v = vc;
    endcase
    chk_eq(tag, 32'(v), 32'(e));
    step();
  endtask

  // Leaves the bench #1 after release, in the first FETCH cycle.
  task automatic do_reset();
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
  endtask

  int exp_ret[5] = '{1, 2, 3, 3, 3};

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0;
    ia.decoded_instruction = I_NOP; ia.zero_op = 0; ia.neg_op = 0; ia.unsigned_overflow = 0; ia.signed_overflow = 0;
    ib.decoded_instruction = I_NOP; ib.zero_op = 0; ib.neg_op = 0; ib.unsigned_overflow = 0; ib.signed_overflow = 0;
    ic.decoded_instruction = I_NOP; ic.zero_op = 0; ic.neg_op = 0; ic.unsigned_overflow = 0; ic.signed_overflow = 0;
    #2;
    chk_eq("rst_a_strobes", 32'(va), 32'(V_IDLE));
    chk_eq("rst_a_retired", 32'(ia.instr_retired), 32'd0);

    // Test 1: A, ADD then HALT.
    ia.decoded_instruction = I_ADD;
    do_reset();
    exp_cyc(0, "t1_c1_fetch", V_IDLE);
    exp_cyc(0, "t1_c2_latch", V_LATCH);
    exp_cyc(0, "t1_c3_decode", V_IDLE);
    exp_cyc(0, "t1_c4_add", V_ADD);
    ia.decoded_instruction = I_HALT;
    chk_eq("t1_ret_after_add", 32'(ia.instr_retired), 32'd1);
    exp_cyc(0, "t1_c5_fetch", V_IDLE);
    exp_cyc(0, "t1_c6_latch", V_LATCH);
    exp_cyc(0, "t1_c7_decode", V_IDLE);
    chk_eq("t1_ret_at_halt", 32'(ia.instr_retired), 32'd2);
    exp_cyc(0, "t1_c8_halt", V_HALT);
    exp_cyc(0, "t1_c9_halt_sticky", V_HALT);
    chk_eq("t1_ret_hold", 32'(ia.instr_retired), 32'd2);

    // Test 3: A, BZERO taken then not taken.
    ia.decoded_instruction = I_BZERO;
    ia.zero_op = 1'b1;
    do_reset();
    chk_eq("t3_ret_reset", 32'(ia.instr_retired), 32'd0);
    exp_cyc(0, "t3_c1_fetch", V_IDLE);
    exp_cyc(0, "t3_c2_latch", V_LATCH);
    exp_cyc(0, "t3_c3_decode", V_IDLE);
    exp_cyc(0, "t3_c4_branch", V_BR);
    ia.zero_op = 1'b0;
    chk_eq("t3_ret_taken", 32'(ia.instr_retired), 32'd1);
    exp_cyc(0, "t3_c5_fetch", V_IDLE);
    exp_cyc(0, "t3_c6_latch", V_LATCH);
    exp_cyc(0, "t3_c7_decode", V_IDLE);
    chk_eq("t3_ret_not_taken", 32'(ia.instr_retired), 32'd2);
    exp_cyc(0, "t3_c8_fetch_no_branch", V_IDLE);
    exp_cyc(0, "t3_c9_latch", V_LATCH);

    // Test 2: B (L=3), LOAD takes 2L+3 = 9 cycles.
    ib.decoded_instruction = I_LOAD;
    do_reset();
    exp_cyc(1, "t2_c1_fetch", V_IDLE);
    exp_cyc(1, "t2_c2_fetch", V_IDLE);
    exp_cyc(1, "t2_c3_fetch", V_IDLE);
    exp_cyc(1, "t2_c4_latch", V_LATCH);
    exp_cyc(1, "t2_c5_decode", V_IDLE);
    exp_cyc(1, "t2_c6_laddr", V_LADDR);
    exp_cyc(1, "t2_c7_laddr", V_LADDR);
    exp_cyc(1, "t2_c8_laddr", V_LADDR);
    exp_cyc(1, "t2_c9_lwb", V_LWB);
    chk_eq("t2_ret", 32'(ib.instr_retired), 32'd1);
    exp_cyc(1, "t2_c10_fetch", V_IDLE);

    // Test 5: B, reset asserted in the middle of the second LOAD's address phase.
    exp_cyc(1, "t5_c11_fetch", V_IDLE);
    exp_cyc(1, "t5_c12_fetch", V_IDLE);
    exp_cyc(1, "t5_c13_latch", V_LATCH);
    exp_cyc(1, "t5_c14_decode", V_IDLE);
    exp_cyc(1, "t5_c15_laddr", V_LADDR);
    chk_eq("t5_c16_laddr", 32'(vb), 32'(V_LADDR));
    rst_n = 1'b0;
    #1;
    chk_eq("t5_async_strobes", 32'(vb), 32'(V_IDLE));
    chk_eq("t5_async_retired", 32'(ib.instr_retired), 32'd0);
    step();
    rst_n = 1'b1;
    exp_cyc(1, "t5_r1_fetch", V_IDLE);
    exp_cyc(1, "t5_r2_fetch", V_IDLE);
    exp_cyc(1, "t5_r3_fetch", V_IDLE);
    exp_cyc(1, "t5_r4_latch", V_LATCH);

    // Test 4: C (OV_SIGNED=0), BOV follows unsigned_overflow only.
    ic.decoded_instruction = I_BOV;
    ic.signed_overflow = 1'b1;
    ic.unsigned_overflow = 1'b0;
    do_reset();
    exp_cyc(2, "t4_c1_fetch", V_IDLE);
    exp_cyc(2, "t4_c2_latch", V_LATCH);
    exp_cyc(2, "t4_c3_decode", V_IDLE);
    exp_cyc(2, "t4_c4_not_taken", V_IDLE);
    ic.signed_overflow = 1'b0;
    ic.unsigned_overflow = 1'b1;
    exp_cyc(2, "t4_c5_latch", V_LATCH);
    exp_cyc(2, "t4_c6_decode", V_IDLE);
    exp_cyc(2, "t4_c7_taken", V_BR);
    chk_eq("t4_ret", 32'(ic.instr_retired), 32'd2);

    // Test 6: C (CNT_W=2), five NOPs saturate at 3, then a STORE.
    ic.decoded_instruction = I_NOP;
    do_reset();
    for (int k = 0; k < 5; k++) begin
      exp_cyc(2, "t6_nop_fetch", V_IDLE);
      exp_cyc(2, "t6_nop_latch", V_LATCH);
      exp_cyc(2, "t6_nop_decode", V_IDLE);
      chk_eq($sformatf("t6_ret_nop%0d", k + 1), 32'(ic.instr_retired), 32'(exp_ret[k]));
    end
    ic.decoded_instruction = I_STORE;
    exp_cyc(2, "t6_st_fetch", V_IDLE);
    exp_cyc(2, "t6_st_latch", V_LATCH);
    exp_cyc(2, "t6_st_decode", V_IDLE);
    exp_cyc(2, "t6_st_write", V_STORE);
    exp_cyc(2, "t6_st_after", V_IDLE);
    chk_eq("t6_ret_sat", 32'(ic.instr_retired), 32'd3);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
